// File: rtl/sent_tx_pkg.sv
// Shared types and helpers for the SENT TX fast-channel frame packer.
// Mode encodings follow the load_bit field of the frame request.
package sent_tx_pkg;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned F1_W   = 16;
    localparam int unsigned F2_W   = 12;

    typedef enum logic [2:0] {
        MODE_NONE    = 3'b000,
        MODE_2W      = 3'b001,
        MODE_1W_A    = 3'b010,
        MODE_1W_B    = 3'b011,
        MODE_1W_C    = 3'b100,
        MODE_1W_D    = 3'b101,
        MODE_SPLIT10 = 3'b110,
        MODE_SPLIT8  = 3'b111
    } load_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PACK    = 2'd2,
        ST_HOLD    = 2'd3
    } state_e;

    typedef struct packed {
        logic [F1_W-1:0] f1;
        logic [F2_W-1:0] f2;
    } frame_t;

    function automatic logic [1:0] words_needed(input load_mode_e mode);
        case (mode)
            MODE_NONE:                          return 2'd0;
            MODE_2W, MODE_SPLIT10, MODE_SPLIT8: return 2'd2;
            default:                            return 2'd1;
        endcase
    endfunction

    // w1 is always the older word; split modes straddle w2 across both channels
    function automatic frame_t pack_frame(input load_mode_e mode,
                                          input logic [DATA_W-1:0] w1,
                                          input logic [DATA_W-1:0] w2);
        frame_t f;
        f = '0;
        case (mode)
            MODE_2W: begin
                f.f1 = {4'b0, w1};
                f.f2 = w2;
            end
            MODE_SPLIT10: begin
                f.f1 = {2'b0, w1, w2[11:10]};
                f.f2 = {2'b0, w2[9:0]};
            end
            MODE_SPLIT8: begin
                f.f1 = {w1, w2[11:8]};
                f.f2 = {4'b0, w2[7:0]};
            end
            default: begin
                f.f1 = {4'b0, w1};
                f.f2 = '0;
            end
        endcase
        return f;
    endfunction

endpackage

// File: rtl/sent_tx_prefetch_q.sv
// Small circular word queue between the TX FIFO and the frame packer.
// One push and up to two pops per cycle; head and next word are visible combinationally.
module sent_tx_prefetch_q
    import sent_tx_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_data,
    input  logic [1:0]               i_pop,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full_c,
    output logic [DATA_W-1:0]        o_head_c,
    output logic [DATA_W-1:0]        o_next_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
            end
            r_wr_ptr <= r_wr_ptr + PTR_W'(i_push);
            r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop);
            r_count  <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    assign o_count  = r_count;
    assign o_full_c = (r_count == CNT_W'(DEPTH));
    assign o_head_c = r_mem[r_rd_ptr];
    assign o_next_c = r_mem[r_rd_ptr + PTR_W'(1)];

endmodule

// File: rtl/sent_tx_frame_packer.sv
// SENT TX fast-channel data stage: paced prefetch from the TX FIFO, then per-request
// packing of 1 or 2 words into F1/F2 with a valid/ready hold and an underflow timeout.
module sent_tx_frame_packer
    import sent_tx_pkg::*;
#(
    parameter int unsigned RD_GAP   = 6,
    parameter int unsigned PF_DEPTH = 2,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic              clk_tx,
    input  logic              reset_n_tx,
    input  logic [2:0]        load_bit_i,
    input  logic              req_i,
    input  logic [DATA_W-1:0] data_fast_i,
    input  logic              fifo_tx_empty_i,
    output logic              read_enable_tx_o,
    output logic [F1_W-1:0]   data_f1_o,
    output logic [F2_W-1:0]   data_f2_o,
    output logic              frame_valid_o,
    input  logic              frame_ready_i,
    output logic              underflow_o,
    output logic              busy_o
);

    localparam int unsigned GAP_W = (RD_GAP > 0) ? $clog2(RD_GAP + 1) : 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_W = $clog2(PF_DEPTH) + 1;

    state_e            r_state;
    state_e            w_state_nxt;
    load_mode_e        r_mode;
    load_mode_e        w_mode_nxt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [TO_W-1:0]   w_to_nxt;
    logic [GAP_W-1:0]  r_gap;
    logic [DATA_W-1:0] r_w1;
    logic [DATA_W-1:0] r_w2;
    logic [DATA_W-1:0] w_w1_nxt;
    logic [DATA_W-1:0] w_w2_nxt;
    logic [F1_W-1:0]   r_f1;
    logic [F2_W-1:0]   r_f2;
    logic [F1_W-1:0]   w_f1_nxt;
    logic [F2_W-1:0]   w_f2_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic              r_underflow;
    logic              w_underflow_nxt;

    logic              w_pop;
    logic [1:0]        w_consume;
    logic [1:0]        w_need;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic [DATA_W-1:0] w_head;
    logic [DATA_W-1:0] w_next;
    frame_t            w_frame;

    sent_tx_prefetch_q #(
        .DEPTH (PF_DEPTH)
    ) u_prefetch_q (
        .clk      (clk_tx),
        .rst_n    (reset_n_tx),
        .i_push   (w_pop),
        .i_data   (data_fast_i),
        .i_pop    (w_consume),
        .o_count  (w_count),
        .o_full_c (w_full),
        .o_head_c (w_head),
        .o_next_c (w_next)
    );

    // fullness is judged before this cycle's consumption, so a draining full queue still skips
    assign w_pop = (r_gap == GAP_W'(RD_GAP)) && !fifo_tx_empty_i && !w_full;

    always_ff @(posedge clk_tx or negedge reset_n_tx) begin
        if (!reset_n_tx) begin
            r_gap <= '0;
        end else if (w_pop) begin
            r_gap <= '0;
        end else if (r_gap != GAP_W'(RD_GAP)) begin
            r_gap <= r_gap + GAP_W'(1);
        end
    end

    assign w_need  = words_needed(r_mode);
    assign w_frame = pack_frame(r_mode, r_w1, r_w2);

    always_ff @(posedge clk_tx or negedge reset_n_tx) begin
        if (!reset_n_tx) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_mode_nxt      = r_mode;
        w_to_nxt        = r_to_cnt;
        w_w1_nxt        = r_w1;
        w_w2_nxt        = r_w2;
        w_f1_nxt        = r_f1;
        w_f2_nxt        = r_f2;
        w_valid_nxt     = r_valid;
        w_underflow_nxt = r_underflow;
        w_consume       = 2'd0;
        case (r_state)
            ST_IDLE: begin
                if (req_i && (load_mode_e'(load_bit_i) != MODE_NONE)) begin
                    w_mode_nxt      = load_mode_e'(load_bit_i);
                    w_underflow_nxt = 1'b0;
                    w_to_nxt        = '0;
                    w_state_nxt     = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (w_count >= CNT_W'(w_need)) begin
                    w_consume   = w_need;
                    w_w1_nxt    = w_head;
                    w_w2_nxt    = (w_need == 2'd2) ? w_next : '0;
                    w_state_nxt = ST_PACK;
                end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                    // count < need here, so whatever is queued is taken and the rest is zero
                    w_consume       = 2'(w_count);
                    w_w1_nxt        = (w_count != '0) ? w_head : '0;
                    w_w2_nxt        = '0;
                    w_underflow_nxt = 1'b1;
                    w_state_nxt     = ST_PACK;
                end else begin
                    w_to_nxt = r_to_cnt + TO_W'(1);
                end
            end
            ST_PACK: begin
                w_f1_nxt    = w_frame.f1;
                w_f2_nxt    = w_frame.f2;
                w_valid_nxt = 1'b1;
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (frame_ready_i) begin
                    w_f1_nxt    = '0;
                    w_f2_nxt    = '0;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_tx or negedge reset_n_tx) begin
        if (!reset_n_tx) begin
            r_mode      <= MODE_NONE;
            r_to_cnt    <= '0;
            r_w1        <= '0;
            r_w2        <= '0;
            r_f1        <= '0;
            r_f2        <= '0;
            r_valid     <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_mode      <= w_mode_nxt;
            r_to_cnt    <= w_to_nxt;
            r_w1        <= w_w1_nxt;
            r_w2        <= w_w2_nxt;
            r_f1        <= w_f1_nxt;
            r_f2        <= w_f2_nxt;
            r_valid     <= w_valid_nxt;
            r_underflow <= w_underflow_nxt;
        end
    end

    assign read_enable_tx_o = w_pop;
    assign data_f1_o        = r_f1;
    assign data_f2_o        = r_f2;
    assign frame_valid_o    = r_valid;
    assign underflow_o      = r_underflow;
    assign busy_o           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sent_tx_frame_packer.sv
// Bench for sent_tx_frame_packer: FIFO model, pop-spacing monitor, scoreboard of expected
// frames, a table of packing vectors and hand-written reset/timeout/ignore/prefetch sequences.
module tb_sent_tx_frame_packer;

    localparam int RD_GAP  = 6;
    localparam int TIMEOUT = 64;

    logic        clk_tx;
    logic        reset_n_tx;
    logic [2:0]  load_bit_i;
    logic        req_i;
    logic [11:0] data_fast_i;
    logic        fifo_tx_empty_i;
    logic        read_enable_tx_o;
    logic [15:0] data_f1_o;
    logic [11:0] data_f2_o;
    logic        frame_valid_o;
    logic        frame_ready_i;
    logic        underflow_o;
    logic        busy_o;

    sent_tx_frame_packer #(
        .RD_GAP   (RD_GAP),
        .PF_DEPTH (2),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_tx           (clk_tx),
        .reset_n_tx       (reset_n_tx),
        .load_bit_i       (load_bit_i),
        .req_i            (req_i),
        .data_fast_i      (data_fast_i),
        .fifo_tx_empty_i  (fifo_tx_empty_i),
        .read_enable_tx_o (read_enable_tx_o),
        .data_f1_o        (data_f1_o),
        .data_f2_o        (data_f2_o),
        .frame_valid_o    (frame_valid_o),
        .frame_ready_i    (frame_ready_i),
        .underflow_o      (underflow_o),
        .busy_o           (busy_o)
    );

    typedef struct {
        logic [2:0]  mode;
        int          nw;
        logic [11:0] w1;
        logic [11:0] w2;
        logic [15:0] f1;
        logic [11:0] f2;
    } vec_t;

    typedef struct {
        logic [15:0] f1;
        logic [11:0] f2;
        logic        uf;
    } exp_t;

    logic [11:0] fifo_q[$];
    exp_t        exp_q[$];
    vec_t        vecs[9];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          n_pops = 0;
    int          last_pop = -1;
    logic        pop_now;

    initial clk_tx = 1'b0;
    always #5 clk_tx = ~clk_tx;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_tx_empty_i = (fifo_q.size() == 0);
        data_fast_i     = (fifo_q.size() != 0) ? fifo_q[0] : 12'h000;
    endtask

    task automatic push_fifo(input logic [11:0] w);
        fifo_q.push_back(w);
        drive_fifo();
    endtask

    // one clock: sample pop on the falling edge, retire the FIFO head after the rising edge
    task automatic tick();
        @(negedge clk_tx);
        pop_now = read_enable_tx_o;
        if (pop_now) begin
            n_pops++;
            if (last_pop >= 0) begin
                checks++;
                if (cyc - last_pop < RD_GAP + 1) begin
                    failures++;
                    $display("FAIL pop_spacing: got %0d cycles required >= %0d", cyc - last_pop, RD_GAP + 1);
                end
            end
            last_pop = cyc;
            if (fifo_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_on_empty: got pop at cycle %0d required none", cyc);
            end
        end
        @(posedge clk_tx);
        #1;
        cyc++;
        if (pop_now && fifo_q.size() != 0) void'(fifo_q.pop_front());
        drive_fifo();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // independent reference: split the 24-bit {w1,w2} stream at the field boundary
    function automatic exp_t model_frame(input logic [2:0] mode, input logic [11:0] w1,
                                         input logic [11:0] w2, input logic uf);
        exp_t        e;
        logic [23:0] cat;
        cat  = {w1, w2};
        e.uf = uf;
        case (mode)
            3'b001: begin e.f1 = {4'h0, w1};         e.f2 = w2;              end
            3'b110: begin e.f1 = 16'(cat[23:10]);    e.f2 = 12'(cat[9:0]);   end
            3'b111: begin e.f1 = cat[23:8];          e.f2 = 12'(cat[7:0]);   end
            default: begin e.f1 = 16'(w1);           e.f2 = 12'h000;         end
        endcase
        return e;
    endfunction

    task automatic check_frame(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_sb: got unexpected frame f1=0x%0h required no frame", tag, data_f1_o);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_f1"}, 32'(data_f1_o), 32'(e.f1));
            chk({tag, "_f2"}, 32'(data_f2_o), 32'(e.f2));
            chk({tag, "_uf"}, 32'(underflow_o), 32'(e.uf));
        end
    endtask

    task automatic run_frame(input logic [2:0] mode, input exp_t e, input int lat_min,
                             input int lat_max, input string tag);
        int n;
        exp_q.push_back(e);
        load_bit_i = mode;
        req_i      = 1'b1;
        tick();
        req_i      = 1'b0;
        load_bit_i = 3'b000;
        n = 0;
        while (frame_valid_o !== 1'b1 && n < lat_max + 4) begin
            tick();
            n++;
        end
        checks++;
        if (frame_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL %s_valid: got no frame after %0d cycles required one", tag, n);
            exp_q.delete();
        end else begin
            if (n < lat_min || n > lat_max) begin
                failures++;
                $display("FAIL %s_latency: got %0d required %0d..%0d", tag, n, lat_min, lat_max);
            end
            check_frame(tag);
        end
    endtask

    task automatic hold_and_accept(input exp_t e, input string tag);
        ticks(3);
        chk({tag, "_hold_valid"}, 32'(frame_valid_o), 32'd1);
        chk({tag, "_hold_f1"}, 32'(data_f1_o), 32'(e.f1));
        chk({tag, "_hold_f2"}, 32'(data_f2_o), 32'(e.f2));
        frame_ready_i = 1'b1;
        tick();
        frame_ready_i = 1'b0;
        chk({tag, "_acc_valid"}, 32'(frame_valid_o), 32'd0);
        chk({tag, "_acc_f1"}, 32'(data_f1_o), 32'd0);
        chk({tag, "_acc_f2"}, 32'(data_f2_o), 32'd0);
        chk({tag, "_acc_busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        exp_t e;
        int   p0;
        int   k;

        vecs[0] = '{mode: 3'b001, nw: 2, w1: 12'hABC, w2: 12'h123, f1: 16'h0ABC, f2: 12'h123};
        vecs[1] = '{mode: 3'b110, nw: 2, w1: 12'hFFF, w2: 12'hC05, f1: 16'h3FFF, f2: 12'h005};
        vecs[2] = '{mode: 3'b111, nw: 2, w1: 12'h800, w2: 12'h5A7, f1: 16'h8005, f2: 12'h0A7};
        vecs[3] = '{mode: 3'b011, nw: 1, w1: 12'h456, w2: 12'h000, f1: 16'h0456, f2: 12'h000};
        vecs[4] = '{mode: 3'b010, nw: 1, w1: 12'h001, w2: 12'h000, f1: 16'h0001, f2: 12'h000};
        vecs[5] = '{mode: 3'b100, nw: 1, w1: 12'h7FF, w2: 12'h000, f1: 16'h07FF, f2: 12'h000};
        vecs[6] = '{mode: 3'b101, nw: 1, w1: 12'hA5A, w2: 12'h000, f1: 16'h0A5A, f2: 12'h000};
        vecs[7] = '{mode: 3'b111, nw: 2, w1: 12'hFFF, w2: 12'hFFF, f1: 16'hFFFF, f2: 12'h0FF};
        vecs[8] = '{mode: 3'b110, nw: 2, w1: 12'h001, w2: 12'h800, f1: 16'h0006, f2: 12'h000};

        reset_n_tx    = 1'b0;
        load_bit_i    = 3'b000;
        req_i         = 1'b0;
        frame_ready_i = 1'b0;
        drive_fifo();
        repeat (3) @(posedge clk_tx);
        #1;
        chk("rst_valid", 32'(frame_valid_o), 32'd0);
        chk("rst_f1", 32'(data_f1_o), 32'd0);
        chk("rst_f2", 32'(data_f2_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_uf", 32'(underflow_o), 32'd0);
        chk("rst_rden", 32'(read_enable_tx_o), 32'd0);
        reset_n_tx = 1'b1;
        ticks(10);

        // packing table: words prefetched ahead, so every frame should land 2 cycles after req
        for (int v = 0; v < 9; v++) begin
            push_fifo(vecs[v].w1);
            if (vecs[v].nw == 2) push_fifo(vecs[v].w2);
            ticks(2 * (RD_GAP + 1) + 4);
            e = '{f1: vecs[v].f1, f2: vecs[v].f2, uf: 1'b0};
            run_frame(vecs[v].mode, e, 2, 2, $sformatf("vec%0d", v));
            hold_and_accept(e, $sformatf("vec%0d", v));
        end

        // underflow: nothing queued, frame zero-padded after the timeout; flag sticks until next req
        run_frame(3'b011, '{f1: 16'h0000, f2: 12'h000, uf: 1'b1}, TIMEOUT, TIMEOUT + 2, "tmo");
        hold_and_accept('{f1: 16'h0000, f2: 12'h000, uf: 1'b1}, "tmo");
        ticks(5);
        chk("tmo_sticky_uf", 32'(underflow_o), 32'd1);
        push_fifo(12'h321);
        ticks(2 * (RD_GAP + 1) + 4);
        e = model_frame(3'b010, 12'h321, 12'h000, 1'b0);
        run_frame(3'b010, e, 2, 2, "uf_clear");
        hold_and_accept(e, "uf_clear");

        // ignored requests: mode 000 in IDLE, any req during HOLD
        push_fifo(12'h111);
        push_fifo(12'h222);
        ticks(2 * (RD_GAP + 1) + 4);
        load_bit_i = 3'b000;
        req_i      = 1'b1;
        tick();
        req_i      = 1'b0;
        chk("mode0_busy", 32'(busy_o), 32'd0);
        ticks(4);
        chk("mode0_valid", 32'(frame_valid_o), 32'd0);
        e = model_frame(3'b001, 12'h111, 12'h222, 1'b0);
        run_frame(3'b001, e, 2, 2, "ign");
        load_bit_i = 3'b111;
        req_i      = 1'b1;
        tick();
        req_i      = 1'b0;
        load_bit_i = 3'b000;
        tick();
        chk("ign_hold_busy", 32'(busy_o), 32'd1);
        hold_and_accept(e, "ign");
        ticks(5);
        chk("ign_after_busy", 32'(busy_o), 32'd0);
        chk("ign_after_valid", 32'(frame_valid_o), 32'd0);

        // prefetch limit: 5 words waiting, queue takes only 2 until a frame drains it
        p0 = n_pops;
        for (int i = 0; i < 5; i++) push_fifo(12'(12'hA01 + i));
        ticks(40);
        chk("pf_pops_full", 32'(n_pops - p0), 32'd2);
        p0 = n_pops;
        e = model_frame(3'b001, 12'hA01, 12'hA02, 1'b0);
        run_frame(3'b001, e, 2, 2, "pf1");
        hold_and_accept(e, "pf1");
        ticks(40);
        chk("pf_pops_resume", 32'(n_pops - p0), 32'd2);
        p0 = n_pops;
        e = model_frame(3'b001, 12'hA03, 12'hA04, 1'b0);
        run_frame(3'b001, e, 2, 2, "pf2");
        hold_and_accept(e, "pf2");
        ticks(40);
        chk("pf_pops_last", 32'(n_pops - p0), 32'd1);
        e = model_frame(3'b010, 12'hA05, 12'h000, 1'b0);
        run_frame(3'b010, e, 2, 2, "pf3");
        hold_and_accept(e, "pf3");

        // reset mid-HOLD with a word still queued: frame and queued word are dropped
        push_fifo(12'h0B1);
        push_fifo(12'h0B2);
        push_fifo(12'h0B3);
        ticks(2 * (RD_GAP + 1) + 4);
        e = model_frame(3'b001, 12'h0B1, 12'h0B2, 1'b0);
        run_frame(3'b001, e, 2, 2, "rstmid");
        ticks(2 * (RD_GAP + 1));
        reset_n_tx = 1'b0;
        tick();
        chk("rstmid_valid", 32'(frame_valid_o), 32'd0);
        chk("rstmid_f1", 32'(data_f1_o), 32'd0);
        chk("rstmid_f2", 32'(data_f2_o), 32'd0);
        chk("rstmid_busy", 32'(busy_o), 32'd0);
        fifo_q.delete();
        push_fifo(12'h0B4);
        push_fifo(12'h0B5);
        reset_n_tx = 1'b1;
        last_pop   = -1;
        p0 = n_pops;
        k  = 0;
        while (n_pops == p0 && k < 4 * (RD_GAP + 1)) begin
            tick();
            k++;
        end
        chk("rst_first_pop_cycle", 32'(k), 32'(RD_GAP + 1));
        ticks(2 * (RD_GAP + 1));
        e = model_frame(3'b001, 12'h0B4, 12'h0B5, 1'b0);
        run_frame(3'b001, e, 2, 2, "post_rst");
        hold_and_accept(e, "post_rst");

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
